// File: rtl/stolic_link_rx.sv
// Neighbor-link receiver: eight directional holding registers, a round-robin merge into a tagged
// FIFO, and a Wishbone slave for the local core. Optional o_irq port under STOLIC_RX_IRQ_EN.
module stolic_link_rx #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = 2
) (
  input  logic          wb_clk,
  input  logic          wb_rst_n,
  input  logic [255:0]  i_link_dat,
  input  logic [7:0]    i_link_vld,
  input  logic          i_wb_cyc,
  input  logic          i_wb_stb,
  input  logic          i_wb_we,
  input  logic [AW-1:0] i_wb_adr,
  input  logic [31:0]   i_wb_dat,
  output logic [31:0]   o_wb_rdt,
`ifdef STOLIC_RX_IRQ_EN
  output logic          o_irq,
`endif
  output logic          o_wb_ack
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = PW + 1;

  logic [31:0]   r_hold [8];
  logic [7:0]    r_hold_vld;
  logic [7:0]    r_ovf;
  logic [7:0]    r_enable;
  logic [2:0]    r_last_grant;
  logic [34:0]   r_mem [DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic          r_ack;
  logic [31:0]   r_rdt;

  logic          w_full;
  logic          w_empty;
  logic [7:0]    w_grant;
  logic [2:0]    w_gnt_dir;
  logic          w_gnt_any;
  logic [2:0]    w_idx;
  logic [7:0]    w_cap;
  logic [7:0]    w_load;
  logic [7:0]    w_drop;
  logic          w_req;
  logic          w_rd;
  logic          w_wr;
  logic          w_sel_data;
  logic          w_sel_status;
  logic          w_sel_enable;
  logic          w_push;
  logic          w_pop;
  logic [34:0]   w_head;
  logic [2:0]    w_head_tag;
  logic [31:0]   w_status;
  logic [31:0]   w_rdata;
  logic [7:0]    w_ovf_nxt;
  logic          w_unused;

  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == '0);

  // Rotating search starting one past the previous winner; i == 8 revisits last_grant itself.
  always_comb begin
    w_grant   = '0;
    w_gnt_dir = r_last_grant;
    w_gnt_any = 1'b0;
    w_idx     = '0;
    if (!w_full) begin
      for (int i = 1; i <= 8; i++) begin
        w_idx = r_last_grant + 3'(i);
        if (!w_gnt_any && r_hold_vld[w_idx]) begin
          w_gnt_any = 1'b1;
          w_gnt_dir = w_idx;
        end
      end
    end
    if (w_gnt_any) w_grant[w_gnt_dir] = 1'b1;
  end

  // A busy hold accepts a new word only when it is being drained in the same cycle.
  assign w_cap  = i_link_vld & r_enable;
  assign w_load = w_cap & (~r_hold_vld | w_grant);
  assign w_drop = w_cap & r_hold_vld & ~w_grant;

  assign w_req        = i_wb_cyc & i_wb_stb & ~r_ack;
  assign w_rd         = w_req & ~i_wb_we;
  assign w_wr         = w_req & i_wb_we;
  assign w_sel_data   = (i_wb_adr == AW'(0));
  assign w_sel_status = (i_wb_adr == AW'(1));
  assign w_sel_enable = (i_wb_adr == AW'(2));

  assign w_push     = w_gnt_any;
  assign w_pop      = w_rd & w_sel_data & ~w_empty;
  assign w_head     = r_mem[r_rptr];
  assign w_head_tag = w_empty ? 3'd0 : w_head[34:32];
  assign w_status   = {r_ovf, 5'd0, w_head_tag, 6'd0, w_full, w_empty, 3'd0, 5'(r_count)};
  assign w_unused   = ^i_wb_dat[23:8];

  // Clear and set are merged so a same-cycle overflow survives the write-1-to-clear.
  assign w_ovf_nxt = ((w_wr && w_sel_status) ? (r_ovf & ~i_wb_dat[31:24]) : r_ovf) | w_drop;

  always_comb begin
    w_rdata = '0;
    if (w_sel_data) begin
      if (!w_empty) w_rdata = w_head[31:0];
    end else if (w_sel_status) begin
      w_rdata = w_status;
    end else if (w_sel_enable) begin
      w_rdata = {24'd0, r_enable};
    end
  end

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      for (int d = 0; d < 8; d++) r_hold[d] <= '0;
      r_hold_vld   <= '0;
      r_ovf        <= '0;
      r_enable     <= 8'hFF;
      r_last_grant <= 3'd7;
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_count      <= '0;
      r_ack        <= 1'b0;
      r_rdt        <= '0;
    end else begin
      for (int d = 0; d < 8; d++) begin
        if (w_load[d]) r_hold[d] <= i_link_dat[32*d +: 32];
      end
      r_hold_vld <= (r_hold_vld & ~w_grant) | w_load;
      r_ovf      <= w_ovf_nxt;
      if (w_wr && w_sel_enable) r_enable <= i_wb_dat[7:0];
      if (w_gnt_any) r_last_grant <= w_gnt_dir;
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop)  r_rptr <= r_rptr + PW'(1);
      if (w_push && !w_pop)      r_count <= r_count + CW'(1);
      else if (!w_push && w_pop) r_count <= r_count - CW'(1);
      r_ack <= w_req;
      r_rdt <= w_rd ? w_rdata : 32'd0;
    end
  end

  // Storage needs no reset: pointers and count define which entries are live.
  always_ff @(posedge wb_clk) begin
    if (w_push) r_mem[r_wptr] <= {w_gnt_dir, r_hold[w_gnt_dir]};
  end

  assign o_wb_ack = r_ack;
  assign o_wb_rdt = r_rdt;

`ifdef STOLIC_RX_IRQ_EN
  logic r_irq;
  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) r_irq <= 1'b0;
    else           r_irq <= ~w_empty | (|r_ovf);
  end
  assign o_irq = r_irq;
`endif

endmodule
